fc_feeder: RTL and testbench
============================

# fc_feeder

Sequencer that drives the fully connected layer's input side. On `start_i` it reads 32 beats of packed feature bytes and weight pairs from synchronous-read buffers. It presents each beat to the FC core as a one-cycle valid pulse, spaced at exactly the core's 13-cycle processing period. It then waits a fixed latency, captures the core's two int8 results and reports them with a `done_o` pulse. It sits between the feature/weight buffers and the FC core.

## Interface
Parameters:
- BEATS, 32: beats per frame; must match the FC core's frame length.
- BEAT_PERIOD, 13: cycles between consecutive `fc_valid_o` pulses; must be ≥ 3.
- RES_LAT, 12: cycles from the last beat pulse to the cycle in which FC results are stable.
- AW, 5: buffer address width; 2^AW ≥ BEATS.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  frame request; accepted only in IDLE
- bias_i  in  32  {bias2[31:16], bias1[15:0]}; latched on start accept
- busy_o  out  1  high from the accept cycle +1 through the `done_o` cycle inclusive
- mem_rd_en_o  out  1  buffer read strobe
- mem_addr_o  out  AW  buffer address, equal to the beat index
- feat_rdata_i  in  72  9 signed bytes, byte i in [8i+7:8i]; valid the cycle after `mem_rd_en_o`
- wgt_rdata_i  in  144  {weight2[71:0], weight1[71:0]}; same timing as `feat_rdata_i`
- fc_valid_o  out  1  one-cycle beat strobe to the FC core
- fc_data_o  out  72  beat features
- fc_weight1_o  out  72  beat weights, neuron 1
- fc_weight2_o  out  72  beat weights, neuron 2
- fc_bias_o  out  32  latched bias, constant for the whole frame
- fc_res1_i, fc_res2_i  in  8  FC core int8 outputs
- done_o  out  1  one-cycle frame-complete pulse
- res1_o, res2_o  out  8  captured results; hold their value until the next `done_o`

## Operation
- States: IDLE → RD → LAT → SEND → GAP → (RD | DRAIN) → DONE → IDLE.
- IDLE: if `start_i` is high, latch `bias_i` into `fc_bias_o`, clear the beat counter, go to RD.
- RD, one cycle: `mem_rd_en_o`=1, `mem_addr_o`=beat.
- LAT, one cycle: on the clock edge ending LAT, register `feat_rdata_i`/`wgt_rdata_i` into `fc_data_o`/`fc_weight1_o`/`fc_weight2_o`.
- SEND, one cycle: `fc_valid_o`=1.
  - Data outputs hold their value until the next LAT load.
  - The beat counter increments.
- GAP: a period counter spans BEAT_PERIOD-3 cycles.
  - When it expires: if beats sent < BEATS, go to RD; otherwise go to DRAIN.
  - The final beat leaves SEND for DRAIN directly; no GAP.
- DRAIN: counts so that `fc_res1_i`/`fc_res2_i` are sampled on the clock edge ending cycle T+RES_LAT, where T is the last SEND cycle.
- DONE, one cycle: `done_o`=1 and `res1_o`/`res2_o` show the new values. The next state is IDLE.
- Start handling:
  - `start_i` outside IDLE is ignored; it is not queued.
  - `start_i` during the DONE cycle is ignored.
- Results are passed through unmodified. No saturation or rescale is applied here.
- Reset mid-frame: all state returns to IDLE and all outputs return to 0 immediately (asynchronous). The FC core is reset by the same `rst_n`.
- Reset values: `busy_o`, `mem_rd_en_o`, `fc_valid_o` and `done_o` = 0. `mem_addr_o`, `fc_data_o`, `fc_weight1_o`, `fc_weight2_o`, `fc_bias_o`, `res1_o` and `res2_o` = 0.

## Timing
Let start be accepted in cycle S.
- Reads: RD at S+1, LAT at S+2.
- Beat pulses: beat k pulses `fc_valid_o` in cycle S+3+k·BEAT_PERIOD.
- Read for beat k+1: issued in cycle S+3+k·BEAT_PERIOD+BEAT_PERIOD-2.
- Last pulse, with defaults: T = S+3+31·13 = S+406.
- Result sample: on the edge ending S+418.
- `done_o`: S+419.
- IDLE: S+420; the earliest next accept is S+420.
- Total frame occupancy with defaults: 420 cycles, accept cycle to the first cycle back in IDLE.
- `fc_valid_o` never asserts on two consecutive cycles. Consecutive pulses are exactly BEAT_PERIOD apart.
- `mem_rd_en_o` asserts exactly BEATS times per frame, with addresses 0..BEATS-1 in order.

## Test plan
- Single frame, defaults:
  - Stimulus: bias_i=0x0002_0001; buffer word k = features 0x01 in every byte, weight1 0x02 in every byte, weight2 0xFF in every byte.
  - Required: 32 pulses at S+3+13k, each with the matching data; `fc_bias_o`=0x00020001 throughout; `done_o` in S+419.
- Result capture:
  - Stimulus: model drives `fc_res1_i`=0x7F and `fc_res2_i`=0x80 from T+12.
  - Required: `res1_o`=0x7F and `res2_o`=0x80 in S+419, held after it; `done_o` high exactly one cycle.
- Start while busy:
  - Stimulus: pulse `start_i` at S+50 and at S+419.
  - Required: both ignored; exactly 32 reads and 32 pulses.
  - Stimulus: `start_i` at S+420.
  - Required: a new frame with RD at S+421.
- Address/read ordering:
  - Stimulus: buffer word k = {k repeated}.
  - Required: `mem_addr_o` takes 0..31 in order; `fc_data_o` bytes equal k at pulse k.
- Reset mid-frame:
  - Stimulus: assert `rst_n`=0 at S+200 for 3 cycles.
  - Required: all outputs go to 0 at once; no `done_o`; a subsequent start runs a full clean frame.
- Back-to-back frames:
  - Stimulus: start held high.
  - Required: frames accepted at S and S+420; the second frame's `done_o` at S+839.

Source files
------------

// File: rtl/fc_feeder.sv
// fc_feeder: input-side sequencer for the fully connected layer.
// On an accepted start it reads BEATS words of packed features and weight
// pairs from synchronous-read buffers and hands each word to the FC core as a
// one-cycle valid strobe. Strobes are spaced exactly BEAT_PERIOD cycles apart.
// After the last beat it waits RES_LAT cycles, captures the two int8 results,
// and reports them with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start_i, bias_i      frame request (IDLE only) and bias latched on accept
//   busy_o               high from accept+1 through the done cycle
//   mem_rd_en_o/addr_o   buffer read strobe and address (= beat index)
//   feat/wgt_rdata_i     buffer read data, valid the cycle after the strobe
//   fc_valid_o, fc_*_o   beat strobe, features, weights and bias to the core
//   fc_res1/2_i          core results
//   done_o, res1/2_o     frame-complete pulse and captured results
module fc_feeder #(
  parameter int BEATS       = 32,
  parameter int BEAT_PERIOD = 13,
  parameter int RES_LAT     = 12,
  parameter int AW          = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [31:0]        bias_i,
  output logic               busy_o,
  output logic               mem_rd_en_o,
  output logic [AW-1:0]      mem_addr_o,
  input  logic [71:0]        feat_rdata_i,
  input  logic [143:0]       wgt_rdata_i,
  output logic               fc_valid_o,
  output logic [71:0]        fc_data_o,
  output logic [71:0]        fc_weight1_o,
  output logic [71:0]        fc_weight2_o,
  output logic [31:0]        fc_bias_o,
  input  logic signed [7:0]  fc_res1_i,
  input  logic signed [7:0]  fc_res2_i,
  output logic               done_o,
  output logic signed [7:0]  res1_o,
  output logic signed [7:0]  res2_o
);

  // One extra bit so the beat counter can hold BEATS itself.
  localparam int BW   = AW + 1;
  localparam int CMAX = (BEAT_PERIOD > RES_LAT) ? BEAT_PERIOD : RES_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LAT, S_SEND, S_GAP, S_DRAIN, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [71:0]      data_q, data_d;
  logic [71:0]      w1_q, w1_d;
  logic [71:0]      w2_q, w2_d;
  logic [31:0]      bias_q, bias_d;
  logic signed [7:0] res1_q, res1_d;
  logic signed [7:0] res2_q, res2_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      bias_q  <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      bias_q  <= bias_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
    end
  end

  // Next-state logic. RD, LAT and SEND take one cycle each, so GAP covers the
  // remaining BEAT_PERIOD-3 cycles of the beat; with BEAT_PERIOD == 3 GAP is
  // skipped entirely. DRAIN lasts RES_LAT cycles so the results are sampled
  // on the edge ending (last SEND + RES_LAT).
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RD;
          beat_d  = '0;
        end
      end
      S_RD:  state_d = S_LAT;
      S_LAT: state_d = S_SEND;
      S_SEND: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == BW'(BEATS - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = CW'(RES_LAT - 1);
        end else if (BEAT_PERIOD == 3) begin
          state_d = S_RD;
        end else begin
          state_d = S_GAP;
          cnt_d   = CW'(BEAT_PERIOD - 4);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_RD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath loads: bias on accept, beat data on the edge ending LAT,
  // results on the edge ending the last DRAIN cycle.
  always_comb begin
    data_d = data_q;
    w1_d   = w1_q;
    w2_d   = w2_q;
    bias_d = bias_q;
    res1_d = res1_q;
    res2_d = res2_q;
    if (state_q == S_IDLE && start_i) bias_d = bias_i;
    if (state_q == S_LAT) begin
      data_d = feat_rdata_i;
      w1_d   = wgt_rdata_i[71:0];
      w2_d   = wgt_rdata_i[143:72];
    end
    if (state_q == S_DRAIN && cnt_q == '0) begin
      res1_d = fc_res1_i;
      res2_d = fc_res2_i;
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    mem_rd_en_o = (state_q == S_RD);
    fc_valid_o  = (state_q == S_SEND);
    done_o      = (state_q == S_DONE);
  end

  assign mem_addr_o   = beat_q[AW-1:0];
  assign fc_data_o    = data_q;
  assign fc_weight1_o = w1_q;
  assign fc_weight2_o = w2_q;
  assign fc_bias_o    = bias_q;
  assign res1_o       = res1_q;
  assign res2_o       = res2_q;

endmodule

// File: tb/tb_fc_feeder.sv
// Testbench for fc_feeder: synchronous-read buffer model, FC result driver
// with per-cycle random values, and a cycle-timing reference computed from
// the frame schedule (S+3+k*BEAT_PERIOD pulses, done at S+419, etc.).
module tb_fc_feeder;
  localparam int BEATS    = 32;
  localparam int BP       = 13;
  localparam int RL       = 12;
  localparam int AW       = 5;
  localparam int T_OFF    = 3 + (BEATS - 1) * BP;
  localparam int DONE_OFF = T_OFF + RL + 1;
  localparam int FRAME    = DONE_OFF + 1;

  logic clk = 1'b0;
  logic rst_n, start_i;
  logic [31:0] bias_i;
  logic busy_o, mem_rd_en_o, fc_valid_o, done_o;
  logic [AW-1:0] mem_addr_o;
  logic [71:0] feat_rdata_i, fc_data_o, fc_weight1_o, fc_weight2_o;
  logic [143:0] wgt_rdata_i;
  logic [31:0] fc_bias_o;
  logic [7:0] fc_res1_i, fc_res2_i, res1_o, res2_o;

  fc_feeder #(.BEATS(BEATS), .BEAT_PERIOD(BP), .RES_LAT(RL), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .bias_i(bias_i),
    .busy_o(busy_o), .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o),
    .feat_rdata_i(feat_rdata_i), .wgt_rdata_i(wgt_rdata_i),
    .fc_valid_o(fc_valid_o), .fc_data_o(fc_data_o),
    .fc_weight1_o(fc_weight1_o), .fc_weight2_o(fc_weight2_o),
    .fc_bias_o(fc_bias_o), .fc_res1_i(fc_res1_i), .fc_res2_i(fc_res2_i),
    .done_o(done_o), .res1_o(res1_o), .res2_o(res2_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer contents and synchronous-read model; garbage when not reading.
  logic [71:0]  feat_mem [BEATS];
  logic [143:0] wgt_mem  [BEATS];
  always @(posedge clk) begin
    if (mem_rd_en_o) begin
      feat_rdata_i <= feat_mem[mem_addr_o];
      wgt_rdata_i  <= wgt_mem[mem_addr_o];
    end else begin
      feat_rdata_i <= 72'({$urandom(), $urandom(), $urandom()});
      wgt_rdata_i  <= 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    end
  end

  // FC result driver: a fresh random value every cycle, logged by cycle,
  // or 0x7F/0x80 from cycle force_from onward.
  logic [7:0] r1_log [16384];
  logic [7:0] r2_log [16384];
  int force_from = 32'h7fff_ffff;
  always @(posedge clk) begin : drv
    logic [7:0] v1, v2;
    if (cyc + 1 >= force_from) begin
      v1 = 8'h7F;
      v2 = 8'h80;
    end else begin
      v1 = 8'($urandom());
      v2 = 8'($urandom());
    end
    fc_res1_i <= v1;
    fc_res2_i <= v2;
    r1_log[(cyc + 1) & 16383] = v1;
    r2_log[(cyc + 1) & 16383] = v2;
  end

  typedef struct { int cyc; logic [71:0] d; logic [71:0] w1; logic [71:0] w2; logic [31:0] b; } pulse_t;
  typedef struct { int cyc; int addr; } rd_t;
  typedef struct { int cyc; logic [7:0] r1; logic [7:0] r2; } done_t;
  pulse_t pulse_q[$];
  rd_t    rd_q[$];
  done_t  done_q[$];
  int consec_viol, busy_cnt;
  logic prev_valid = 1'b0;
  int n_cmp = 0, n_err = 0;

  always @(negedge clk) begin : mon
    pulse_t p;
    rd_t r;
    done_t d;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (fc_valid_o) begin
        p.cyc = cyc; p.d = fc_data_o; p.w1 = fc_weight1_o; p.w2 = fc_weight2_o; p.b = fc_bias_o;
        pulse_q.push_back(p);
        if (prev_valid) consec_viol++;
      end
      prev_valid = fc_valid_o;
      if (mem_rd_en_o) begin
        r.cyc = cyc; r.addr = int'(mem_addr_o);
        rd_q.push_back(r);
      end
      if (done_o) begin
        d.cyc = cyc; d.r1 = res1_o; d.r2 = res2_o;
        done_q.push_back(d);
      end
      if (busy_o) busy_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic launch(output int s);
    pulse_q.delete(); rd_q.delete(); done_q.delete();
    consec_viol = 0; busy_cnt = 0;
    start_i = 1'b1;
    s = cyc;
    step(1);
    start_i = 1'b0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < BEATS; k++) begin
      feat_mem[k] = 72'({$urandom(), $urandom(), $urandom()});
      wgt_mem[k]  = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; bias_i = '0;
    step(3);
    n_cmp++; if ({busy_o, mem_rd_en_o, fc_valid_o, done_o} !== 4'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 0000", {busy_o, mem_rd_en_o, fc_valid_o, done_o}); end
    n_cmp++; if (mem_addr_o !== '0) begin n_err++; $display("FAIL reset_addr: got %0h want 0", mem_addr_o); end
    n_cmp++; if ({fc_data_o, fc_weight1_o, fc_weight2_o} !== '0) begin n_err++; $display("FAIL reset_data: got %0h want 0", {fc_data_o, fc_weight1_o, fc_weight2_o}); end
    n_cmp++; if ({fc_bias_o, res1_o, res2_o} !== '0) begin n_err++; $display("FAIL reset_bias_res: got %0h want 0", {fc_bias_o, res1_o, res2_o}); end
    rst_n = 1'b1;
    step(2);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_single_frame();
    int s;
    for (int k = 0; k < BEATS; k++) begin
      feat_mem[k] = {9{8'h01}};
      wgt_mem[k]  = {{9{8'hFF}}, {9{8'h02}}};
    end
    bias_i = 32'h0002_0001;
    launch(s);
    bias_i = 32'hDEAD_BEEF;
    to_cycle(s + FRAME + 2);
    n_cmp++; if (pulse_q.size() != BEATS) begin n_err++; $display("FAIL single_pulses: got %0d want %0d", pulse_q.size(), BEATS); end
    for (int k = 0; k < pulse_q.size() && k < BEATS; k++) begin
      n_cmp++; if (pulse_q[k].cyc != s + 3 + k * BP) begin n_err++; $display("FAIL single_pulse_cyc[%0d]: got %0d want %0d", k, pulse_q[k].cyc - s, 3 + k * BP); end
      n_cmp++; if ({pulse_q[k].d, pulse_q[k].w1, pulse_q[k].w2, pulse_q[k].b} !== {{9{8'h01}}, {9{8'h02}}, {9{8'hFF}}, 32'h0002_0001})
        begin n_err++; $display("FAIL single_payload[%0d]: got %0h %0h %0h %0h", k, pulse_q[k].d, pulse_q[k].w1, pulse_q[k].w2, pulse_q[k].b); end
    end
    n_cmp++; if (done_q.size() != 1 || done_q[0].cyc != s + DONE_OFF) begin n_err++; $display("FAIL single_done: got count %0d want 1 at S+%0d", done_q.size(), DONE_OFF); end
  endtask

  task automatic test_result_capture();
    int s;
    fill_random();
    bias_i = $urandom();
    launch(s);
    force_from = s + T_OFF + RL;
    to_cycle(s + DONE_OFF);
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL cap_done: got %b want 1", done_o); end
    n_cmp++; if ({res1_o, res2_o} !== 16'h7F80) begin n_err++; $display("FAIL cap_res: got %h want 7f80", {res1_o, res2_o}); end
    step(1);
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL cap_done_width: got %b want 0", done_o); end
    force_from = 32'h7fff_ffff;
    step(6);
    n_cmp++; if ({res1_o, res2_o} !== 16'h7F80) begin n_err++; $display("FAIL cap_hold: got %h want 7f80", {res1_o, res2_o}); end
    n_cmp++; if (done_q.size() != 1) begin n_err++; $display("FAIL cap_done_count: got %0d want 1", done_q.size()); end
  endtask

  task automatic test_addr_order();
    int s;
    for (int k = 0; k < BEATS; k++) begin
      feat_mem[k] = {9{8'(k)}};
      wgt_mem[k]  = {18{8'(k)}};
    end
    launch(s);
    to_cycle(s + FRAME);
    n_cmp++; if (rd_q.size() != BEATS) begin n_err++; $display("FAIL addr_reads: got %0d want %0d", rd_q.size(), BEATS); end
    for (int k = 0; k < rd_q.size() && k < BEATS; k++) begin
      n_cmp++; if (rd_q[k].addr != k) begin n_err++; $display("FAIL addr_order[%0d]: got %0d want %0d", k, rd_q[k].addr, k); end
    end
    for (int k = 0; k < pulse_q.size() && k < BEATS; k++) begin
      n_cmp++; if (pulse_q[k].d !== {9{8'(k)}}) begin n_err++; $display("FAIL addr_data[%0d]: got %0h want %0h", k, pulse_q[k].d, {9{8'(k)}}); end
    end
  endtask

  task automatic test_random_frames();
    int s;
    logic [31:0] eb;
    for (int f = 0; f < 3; f++) begin
      fill_random();
      bias_i = $urandom();
      eb = bias_i;
      launch(s);
      bias_i = $urandom();
      to_cycle(s + FRAME);
      n_cmp++; if (pulse_q.size() != BEATS) begin n_err++; $display("FAIL rnd_pulses: got %0d want %0d", pulse_q.size(), BEATS); end
      for (int k = 0; k < pulse_q.size() && k < BEATS; k++) begin
        n_cmp++; if (pulse_q[k].cyc != s + 3 + k * BP) begin n_err++; $display("FAIL rnd_pulse_cyc[%0d]: got S+%0d want S+%0d", k, pulse_q[k].cyc - s, 3 + k * BP); end
        n_cmp++; if ({pulse_q[k].d, pulse_q[k].w1, pulse_q[k].w2, pulse_q[k].b} !== {feat_mem[k], wgt_mem[k][71:0], wgt_mem[k][143:72], eb})
          begin n_err++; $display("FAIL rnd_payload[%0d]: got %0h want %0h", k, {pulse_q[k].d, pulse_q[k].w1, pulse_q[k].w2, pulse_q[k].b}, {feat_mem[k], wgt_mem[k][71:0], wgt_mem[k][143:72], eb}); end
      end
      n_cmp++; if (rd_q.size() != BEATS) begin n_err++; $display("FAIL rnd_reads: got %0d want %0d", rd_q.size(), BEATS); end
      for (int k = 0; k < rd_q.size() && k < BEATS; k++) begin
        n_cmp++; if (rd_q[k].cyc != s + 1 + k * BP || rd_q[k].addr != k) begin n_err++; $display("FAIL rnd_read[%0d]: got S+%0d addr %0d want S+%0d addr %0d", k, rd_q[k].cyc - s, rd_q[k].addr, 1 + k * BP, k); end
      end
      n_cmp++; if (done_q.size() != 1) begin n_err++; $display("FAIL rnd_done_count: got %0d want 1", done_q.size()); end
      if (done_q.size() >= 1) begin
        n_cmp++; if (done_q[0].cyc != s + DONE_OFF) begin n_err++; $display("FAIL rnd_done_cyc: got S+%0d want S+%0d", done_q[0].cyc - s, DONE_OFF); end
        n_cmp++; if ({done_q[0].r1, done_q[0].r2} !== {r1_log[(s + T_OFF + RL) & 16383], r2_log[(s + T_OFF + RL) & 16383]})
          begin n_err++; $display("FAIL rnd_res: got %h want %h", {done_q[0].r1, done_q[0].r2}, {r1_log[(s + T_OFF + RL) & 16383], r2_log[(s + T_OFF + RL) & 16383]}); end
      end
      n_cmp++; if (busy_cnt != DONE_OFF) begin n_err++; $display("FAIL rnd_busy_cycles: got %0d want %0d", busy_cnt, DONE_OFF); end
      n_cmp++; if (consec_viol != 0) begin n_err++; $display("FAIL rnd_consec_valid: got %0d want 0", consec_viol); end
      step($urandom_range(0, 3));
    end
  endtask

  task automatic test_start_busy();
    int s, np, nr, nd, first_rd2;
    fill_random();
    launch(s);
    to_cycle(s + 50);
    start_i = 1'b1; step(1); start_i = 1'b0;
    to_cycle(s + DONE_OFF);
    start_i = 1'b1;
    step(1);
    step(1);
    start_i = 1'b0;
    to_cycle(s + 2 * FRAME + 2);
    np = 0; nr = 0; nd = 0; first_rd2 = -1;
    foreach (pulse_q[i]) if (pulse_q[i].cyc < s + FRAME) np++;
    foreach (rd_q[i]) begin
      if (rd_q[i].cyc < s + FRAME) nr++;
      else if (first_rd2 < 0) first_rd2 = rd_q[i].cyc;
    end
    foreach (done_q[i]) if (done_q[i].cyc < s + FRAME) nd++;
    n_cmp++; if (np != BEATS) begin n_err++; $display("FAIL busy_pulses: got %0d want %0d", np, BEATS); end
    n_cmp++; if (nr != BEATS) begin n_err++; $display("FAIL busy_reads: got %0d want %0d", nr, BEATS); end
    n_cmp++; if (nd != 1) begin n_err++; $display("FAIL busy_done_first: got %0d want 1", nd); end
    n_cmp++; if (first_rd2 != s + FRAME + 1) begin n_err++; $display("FAIL busy_restart_rd: got S+%0d want S+%0d", first_rd2 - s, FRAME + 1); end
    n_cmp++; if (done_q.size() != 2) begin n_err++; $display("FAIL busy_done_total: got %0d want 2", done_q.size()); end
  endtask

  task automatic test_reset_mid();
    int s;
    fill_random();
    bias_i = $urandom() | 32'h1;
    launch(s);
    to_cycle(s + 200);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy_o, mem_rd_en_o, fc_valid_o, done_o} !== 4'b0) begin n_err++; $display("FAIL rstmid_ctrl: got %b want 0000", {busy_o, mem_rd_en_o, fc_valid_o, done_o}); end
    n_cmp++; if ({fc_data_o, fc_weight1_o, fc_weight2_o, fc_bias_o, mem_addr_o} !== '0) begin n_err++; $display("FAIL rstmid_data: got %0h want 0", {fc_data_o, fc_weight1_o, fc_weight2_o, fc_bias_o, mem_addr_o}); end
    step(3);
    rst_n = 1'b1;
    to_cycle(s + 450);
    n_cmp++; if (done_q.size() != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d want 0", done_q.size()); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %b want 0", busy_o); end
    fill_random();
    bias_i = 32'h1234_5678;
    launch(s);
    to_cycle(s + FRAME);
    n_cmp++; if (pulse_q.size() != BEATS) begin n_err++; $display("FAIL rstmid_pulses: got %0d want %0d", pulse_q.size(), BEATS); end
    if (pulse_q.size() >= 1) begin
      n_cmp++; if ({pulse_q[0].d, pulse_q[0].b} !== {feat_mem[0], 32'h1234_5678}) begin n_err++; $display("FAIL rstmid_beat0: got %0h want %0h", {pulse_q[0].d, pulse_q[0].b}, {feat_mem[0], 32'h1234_5678}); end
    end
    n_cmp++; if (done_q.size() != 1 || done_q[0].cyc != s + DONE_OFF) begin n_err++; $display("FAIL rstmid_done: got count %0d want 1 at S+%0d", done_q.size(), DONE_OFF); end
  endtask

  task automatic test_back_to_back();
    int s;
    fill_random();
    pulse_q.delete(); rd_q.delete(); done_q.delete();
    start_i = 1'b1;
    s = cyc;
    to_cycle(s + FRAME + 1);
    start_i = 1'b0;
    to_cycle(s + 2 * FRAME + 2);
    n_cmp++; if (done_q.size() != 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", done_q.size()); end
    if (done_q.size() >= 2) begin
      n_cmp++; if (done_q[0].cyc != s + DONE_OFF) begin n_err++; $display("FAIL b2b_done1: got S+%0d want S+%0d", done_q[0].cyc - s, DONE_OFF); end
      n_cmp++; if (done_q[1].cyc != s + FRAME + DONE_OFF) begin n_err++; $display("FAIL b2b_done2: got S+%0d want S+%0d", done_q[1].cyc - s, FRAME + DONE_OFF); end
    end
    n_cmp++; if (rd_q.size() != 2 * BEATS) begin n_err++; $display("FAIL b2b_reads: got %0d want %0d", rd_q.size(), 2 * BEATS); end
    if (pulse_q.size() > BEATS) begin
      n_cmp++; if (pulse_q[BEATS].cyc != s + FRAME + 3) begin n_err++; $display("FAIL b2b_second_pulse: got S+%0d want S+%0d", pulse_q[BEATS].cyc - s, FRAME + 3); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_result_capture();
    test_addr_order();
    test_random_frames();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
